// File: rtl/score_bcd_packer.sv
// Pong score keeper: two saturating score counters, win detection, and a shared
// double-dabble converter that publishes both scores as one packed BCD display word.
module score_bcd_packer #(
   parameter int unsigned SCORE_W   = 8,
   parameter int unsigned WIN_SCORE = 11
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        point_l,
   input  logic        point_r,
   input  logic        game_clr,
   output logic [31:0] x,
   output logic        busy,
   output logic        game_over,
   output logic        winner
);

   localparam int unsigned BCD_W  = 12;
   localparam int unsigned PAIR_W = BCD_W + SCORE_W;
   localparam int unsigned CNT_W  = $clog2(SCORE_W + 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_PACK} state_t;

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
   logic [SCORE_W-1:0] bin_l_q, bin_l_d, bin_r_q, bin_r_d;
   logic [BCD_W-1:0]   bcd_l_q, bcd_l_d, bcd_r_q, bcd_r_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        x_q, x_d;
   logic               busy_q, busy_d;
   logic               game_over_q, game_over_d;
   logic               winner_q, winner_d;
   logic               dirty_q, dirty_d;
   logic               inc_l, inc_r;
   logic [PAIR_W-1:0]  pair_l, pair_r;

   // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
   function automatic logic [BCD_W-1:0] adj3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int k = 0; k < 3; k++) begin
         if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= S_IDLE;
         score_l_q   <= '0;
         score_r_q   <= '0;
         bin_l_q     <= '0;
         bin_r_q     <= '0;
         bcd_l_q     <= '0;
         bcd_r_q     <= '0;
         cnt_q       <= '0;
         x_q         <= '0;
         busy_q      <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
         dirty_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         bin_l_q     <= bin_l_d;
         bin_r_q     <= bin_r_d;
         bcd_l_q     <= bcd_l_d;
         bcd_r_q     <= bcd_r_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         busy_q      <= busy_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
         dirty_q     <= dirty_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      bin_l_d     = bin_l_q;
      bin_r_d     = bin_r_q;
      bcd_l_d     = bcd_l_q;
      bcd_r_d     = bcd_r_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      busy_d      = busy_q;
      game_over_d = game_over_q;
      winner_d    = winner_q;
      dirty_d     = dirty_q;
      inc_l       = point_l && (score_l_q != SCORE_MAX);
      inc_r       = point_r && (score_r_q != SCORE_MAX);
      pair_l      = {adj3(bcd_l_q), bin_l_q} << 1;
      pair_r      = {adj3(bcd_r_q), bin_r_q} << 1;

      case (state_q)
         S_IDLE: begin
            if (dirty_q) begin
               dirty_d = 1'b0;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            bin_l_d = score_l_q;
            bin_r_d = score_r_q;
            bcd_l_d = '0;
            bcd_r_d = '0;
            cnt_d   = CNT_W'(SCORE_W);
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            bcd_l_d = pair_l[PAIR_W-1:SCORE_W];
            bin_l_d = pair_l[SCORE_W-1:0];
            bcd_r_d = pair_r[PAIR_W-1:SCORE_W];
            bin_r_d = pair_r[SCORE_W-1:0];
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_PACK;
         end
         S_PACK: begin
            x_d     = {(game_over_q && !winner_q) ? 4'h1 : 4'h0, bcd_l_q,
                       (game_over_q &&  winner_q) ? 4'h1 : 4'h0, bcd_r_q};
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Score updates override the IDLE dirty-clear so no event is lost.
      if (game_clr) begin
         score_l_d   = '0;
         score_r_d   = '0;
         game_over_d = 1'b0;
         winner_d    = 1'b0;
         dirty_d     = 1'b1;
      end else if (!game_over_q) begin
         score_l_d = score_l_q + SCORE_W'(inc_l);
         score_r_d = score_r_q + SCORE_W'(inc_r);
         if (inc_l || inc_r) dirty_d = 1'b1;
         if (score_l_d == WIN_VAL) begin
            game_over_d = 1'b1;
            winner_d    = 1'b0;
         end else if (score_r_d == WIN_VAL) begin
            game_over_d = 1'b1;
            winner_d    = 1'b1;
         end
      end
   end

   assign x         = x_q;
   assign busy      = busy_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;

endmodule

// File: tb/tb_score_bcd_packer.sv
// Bench for score_bcd_packer: directed steps plus random games, checked against a
// decimal-arithmetic score model. Instance a uses WIN_SCORE=11, instance b uses 255.
module tb_score_bcd_packer;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        pl_a = 1'b0, pr_a = 1'b0, gc_a = 1'b0;
   logic        pl_b = 1'b0, pr_b = 1'b0, gc_b = 1'b0;
   logic [31:0] x_a, x_b;
   logic        busy_a, busy_b, go_a, go_b, win_a, win_b;

   int  n_assert = 0;
   int  n_fail   = 0;
   bit  watch    = 1'b0;
   int  sl [2];
   int  sr [2];
   bit  mgo [2];
   bit  mwn [2];
   int  win_v [2] = '{11, 255};

   score_bcd_packer #(.SCORE_W(8), .WIN_SCORE(11)) dut_a (
      .clk(clk), .clr_n(clr_n), .point_l(pl_a), .point_r(pr_a), .game_clr(gc_a),
      .x(x_a), .busy(busy_a), .game_over(go_a), .winner(win_a));

   score_bcd_packer #(.SCORE_W(8), .WIN_SCORE(255)) dut_b (
      .clk(clk), .clr_n(clr_n), .point_l(pl_b), .point_r(pr_b), .game_clr(gc_b),
      .x(x_b), .busy(busy_b), .game_over(go_b), .winner(win_b));

   always #5 clk = ~clk;

   function automatic logic [11:0] bcd3(input int s);
      return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   function automatic logic [31:0] exp_x(input int i);
      return {(mgo[i] && !mwn[i]) ? 4'h1 : 4'h0, bcd3(sl[i]),
              (mgo[i] &&  mwn[i]) ? 4'h1 : 4'h0, bcd3(sr[i])};
   endfunction

   function automatic logic [31:0] get_x(input int i);
      return (i == 0) ? x_a : x_b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         sl[i] = 0; sr[i] = 0; mgo[i] = 1'b0; mwn[i] = 1'b0;
      end
   endtask

   task automatic model_edge(input int i, input bit l, input bit r, input bit gc);
      if (gc) begin
         sl[i] = 0; sr[i] = 0; mgo[i] = 1'b0; mwn[i] = 1'b0;
      end else if (!mgo[i]) begin
         if (l && sl[i] < 255) sl[i]++;
         if (r && sr[i] < 255) sr[i]++;
         if (sl[i] == win_v[i]) begin
            mgo[i] = 1'b1; mwn[i] = 1'b0;
         end else if (sr[i] == win_v[i]) begin
            mgo[i] = 1'b1; mwn[i] = 1'b1;
         end
      end
   endtask

   // While watching, instance a must only ever show a fully converted back-to-back value.
   task automatic watch_chk();
      if (watch)
         chk("no_garbage", 32'((x_a[31:16] == 16'h0001) && (x_a[15:0] >= 16'd1) &&
                               (x_a[15:0] <= 16'd4)), 32'd1);
   endtask

   // One clock with the given pulses on instance i; called and returns at a negedge.
   task automatic step(input int i, input bit l, input bit r, input bit gc);
      if (i == 0) begin pl_a = l; pr_a = r; gc_a = gc; end
      else        begin pl_b = l; pr_b = r; gc_b = gc; end
      @(posedge clk);
      model_edge(i, l, r, gc);
      @(negedge clk);
      pl_a = 1'b0; pr_a = 1'b0; gc_a = 1'b0;
      pl_b = 1'b0; pr_b = 1'b0; gc_b = 1'b0;
      watch_chk();
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         watch_chk();
      end
   endtask

   task automatic check_idle(input int i, input string tag);
      chk({tag, "_x"}, get_x(i), exp_x(i));
      chk({tag, "_busy"}, 32'((i == 0) ? busy_a : busy_b), 32'(0));
      chk({tag, "_game_over"}, 32'((i == 0) ? go_a : go_b), 32'(mgo[i]));
      if (mgo[i]) chk({tag, "_winner"}, 32'((i == 0) ? win_a : win_b), 32'(mwn[i]));
   endtask

   task automatic pulses_b(input int n);
      for (int c = 0; c < n; c++) step(1, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      // Reset held for 5 clocks, then idle.
      repeat (5) @(negedge clk);
      clr_n = 1'b1;
      idle(20);
      check_idle(0, "reset_a");
      check_idle(1, "reset_b");

      // Single point: busy one clock later, x updates exactly 11 clocks after the pulse edge.
      step(0, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k == 1)  chk("lat_busy_rise", 32'(busy_a), 32'(1));
         if (k == 10) chk("lat_x_before", x_a, 32'h0000_0000);
         if (k == 11) begin
            chk("lat_x_at_11", x_a, exp_x(0));
            chk("lat_busy_fall", 32'(busy_a), 32'(0));
         end
      end
      idle(5);

      // Simultaneous points.
      step(0, 1'b0, 1'b0, 1'b1);
      idle(30);
      step(0, 1'b1, 1'b1, 1'b0);
      idle(30);
      check_idle(0, "simul");

      // Three right points two clocks apart during busy; no intermediate garbage.
      watch = 1'b1;
      step(0, 1'b0, 1'b1, 1'b0);
      idle(1);
      step(0, 1'b0, 1'b1, 1'b0);
      idle(1);
      step(0, 1'b0, 1'b1, 1'b0);
      idle(30);
      watch = 1'b0;
      check_idle(0, "b2b");

      // Asynchronous reset during SHIFT aborts at once.
      step(0, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk("pre_abort_busy", 32'(busy_a), 32'(1));
      clr_n = 1'b0;
      #1;
      chk("abort_x", x_a, 32'h0000_0000);
      chk("abort_busy", 32'(busy_a), 32'(0));
      chk("abort_game_over", 32'(go_a), 32'(0));
      model_reset();
      @(negedge clk);
      clr_n = 1'b1;
      idle(30);
      check_idle(0, "post_abort");

      // Right wins 11-7; further left point is ignored.
      for (int c = 0; c < 7; c++) step(0, 1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) step(0, 1'b0, 1'b1, 1'b0);
      idle(30);
      check_idle(0, "win");
      step(0, 1'b1, 1'b0, 1'b0);
      idle(30);
      check_idle(0, "win_hold");

      // game_clr wins over a same-cycle point.
      step(0, 1'b1, 1'b0, 1'b1);
      idle(30);
      check_idle(0, "clr_pt");

      // BCD carries and saturation on the WIN_SCORE=255 instance.
      pulses_b(9);   idle(30); check_idle(1, "bcd9");
      pulses_b(1);   idle(30); check_idle(1, "bcd10");
      pulses_b(189); idle(30); check_idle(1, "bcd199");
      pulses_b(1);   idle(30); check_idle(1, "bcd200");
      pulses_b(54);  idle(30); check_idle(1, "bcd254");
      pulses_b(2);   idle(30); check_idle(1, "bcd255_sat");

      // Random games on both instances.
      for (int rnd = 0; rnd < 8; rnd++) begin
         for (int c = 0; c < 60; c++)
            step(rnd % 2, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0);
         idle(30);
         check_idle(rnd % 2, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
